// File: rtl/fluxo_dados_jogo.sv
// Datapath of the memory game: address counter, fixed 16x4 sequence ROM, play register,
// button edge detector and optional inactivity timer (built only with FLUXO_TIMEOUT_EN defined).
module fluxo_dados_jogo #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       zeraC,
   input  logic       contaC,
   input  logic       zeraR,
   input  logic       registraR,
   input  logic [3:0] chaves,
   output logic       jogada,
   output logic       igual,
   output logic       fim,
   output logic       timeout,
   output logic [3:0] db_contagem,
   output logic [3:0] db_memoria,
   output logic [3:0] db_jogada,
   output logic       db_tem_jogada
);

   logic [3:0] endereco_q, endereco_d;
   logic [3:0] registro_q, registro_d;
   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       tem_jogada;
   logic [3:0] mem_dado;

   function automatic logic [3:0] rom_read(input logic [3:0] addr);
      logic [3:0] dado;
      case (addr)
         4'h0:    dado = 4'h1;
         4'h1:    dado = 4'h2;
         4'h2:    dado = 4'h4;
         4'h3:    dado = 4'h8;
         4'h4:    dado = 4'h4;
         4'h5:    dado = 4'h2;
         4'h6:    dado = 4'h1;
         4'h7:    dado = 4'h1;
         4'h8:    dado = 4'h2;
         4'h9:    dado = 4'h2;
         4'hA:    dado = 4'h4;
         4'hB:    dado = 4'h4;
         4'hC:    dado = 4'h8;
         4'hD:    dado = 4'h8;
         4'hE:    dado = 4'h1;
         default: dado = 4'h4;
      endcase
      return dado;
   endfunction

   assign tem_jogada = |chaves;

   always_comb begin
      endereco_d = endereco_q;
      if (zeraC) begin
         endereco_d = 4'h0;
      end else if (contaC) begin
         endereco_d = endereco_q + 4'h1;
      end
   end

   always_comb begin
      registro_d = registro_q;
      if (zeraR) begin
         registro_d = 4'h0;
      end else if (registraR) begin
         registro_d = chaves;
      end
   end

   // Two-flop edge detector: one pulse per press, none while held.
   always_comb begin
      s1_d = tem_jogada;
      s2_d = s1_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         endereco_q <= 4'h0;
         registro_q <= 4'h0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
      end else begin
         endereco_q <= endereco_d;
         registro_q <= registro_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   assign mem_dado      = rom_read(endereco_q);
   assign jogada        = s1_q & ~s2_q;
   assign igual         = (registro_q == mem_dado);
   assign fim           = (endereco_q == 4'hF);
   assign db_contagem   = endereco_q;
   assign db_memoria    = mem_dado;
   assign db_jogada     = registro_q;
   assign db_tem_jogada = tem_jogada;

`ifdef FLUXO_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] timer_q, timer_d;

   // Any player or controller activity restarts the count; otherwise it saturates.
   always_comb begin
      timer_d = timer_q;
      if (zeraC || contaC || jogada) begin
         timer_d = '0;
      end else if (timer_q != TMR_MAX) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign timeout = (timer_q == TMR_MAX);
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Self-checking bench for fluxo_dados_jogo: directed scenarios plus randomized traffic
// compared against a behavioural model (timeout expectations follow FLUXO_TIMEOUT_EN).
module tb_fluxo_dados_jogo;

   localparam int TO = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       zeraC = 1'b0, contaC = 1'b0, zeraR = 1'b0, registraR = 1'b0;
   logic [3:0] chaves = 4'h0;
   logic       jogada, igual, fim, timeout, db_tem_jogada;
   logic [3:0] db_contagem, db_memoria, db_jogada;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_addr, m_play, m_idle;
   bit samp_q[$];
   int rom [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

   fluxo_dados_jogo #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .zeraC(zeraC), .contaC(contaC),
      .zeraR(zeraR), .registraR(registraR), .chaves(chaves),
      .jogada(jogada), .igual(igual), .fim(fim), .timeout(timeout),
      .db_contagem(db_contagem), .db_memoria(db_memoria),
      .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // A press pulse exists when the newest sample of "any button" is high and the one before was not.
   function automatic bit m_jog();
      if (samp_q.size() == 0) return 1'b0;
      if (samp_q.size() == 1) return samp_q[0];
      return samp_q[samp_q.size()-1] && !samp_q[samp_q.size()-2];
   endfunction

   function automatic bit m_timeout();
`ifdef FLUXO_TIMEOUT_EN
      return m_idle >= TO - 1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_addr = 0;
      m_play = 0;
      m_idle = 0;
      samp_q.delete();
   endtask

   // Called at a falling edge: drive, compare all outputs, clock once, update the model.
   task automatic step(input bit zc, input bit cc, input bit zr, input bit rr, input logic [3:0] ch);
      bit j;
      zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
      #1;
      chk("db_contagem", db_contagem, m_addr);
      chk("db_memoria", db_memoria, rom[m_addr]);
      chk("db_jogada", db_jogada, m_play);
      chk("fim", fim, m_addr == 15);
      chk("igual", igual, m_play == rom[m_addr]);
      chk("jogada", jogada, m_jog());
      chk("timeout", timeout, m_timeout());
      chk("db_tem_jogada", db_tem_jogada, ch != 4'h0);
      @(posedge clock);
      j = m_jog();
      if (zc) m_addr = 0;
      else if (cc) m_addr = (m_addr + 1) % 16;
      if (zr) m_play = 0;
      else if (rr) m_play = int'(ch);
      if (zc || cc || j) m_idle = 0;
      else if (m_idle < 1000) m_idle++;
      samp_q.push_back(ch != 4'h0);
      if (samp_q.size() > 4) void'(samp_q.pop_front());
      @(negedge clock);
   endtask

   // Asynchronous reset raised between edges; its effect is checked before the next edge.
   task automatic do_reset(input logic [3:0] ch);
      zeraC = 0; contaC = 0; zeraR = 0; registraR = 0; chaves = ch;
      #2 reset = 1'b1;
      #1;
      chk("rst_contagem", db_contagem, 4'h0);
      chk("rst_jogada_reg", db_jogada, 4'h0);
      chk("rst_memoria", db_memoria, 4'h1);
      chk("rst_fim", fim, 1'b0);
      chk("rst_igual", igual, 1'b0);
      chk("rst_jogada", jogada, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int pulses, tem, k;
      logic [3:0] ch;
      model_reset();
      @(negedge clock);
      do_reset(4'h0);

      // Single press held three cycles
      pulses = 0; tem = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, (i < 3) ? 4'h1 : 4'h0);
         pulses += int'(jogada);
         tem    += int'(db_tem_jogada);
      end
      chk("press_pulses", pulses, 1);
      chk("press_tem_cycles", tem, 3);

      // Play register compare
      do_reset(4'h0);
      step(0, 0, 0, 1, 4'h1);
      chk("reg_load1", db_jogada, 4'h1);
      chk("igual_match", igual, 1'b1);
      step(0, 0, 0, 1, 4'h2);
      chk("igual_mismatch", igual, 1'b0);
      step(0, 0, 1, 1, 4'h4);
      chk("zeraR_priority", db_jogada, 4'h0);

      // Address sweep and wrap
      do_reset(4'h0);
      for (int i = 0; i < 16; i++) begin
         chk("sweep_fim", fim, i == 15);
         if (i == 15) chk("sweep_memF", db_memoria, 4'h4);
         step(0, 1, 0, 0, 4'h0);
      end
      chk("wrap_addr", db_contagem, 4'h0);
      chk("wrap_fim", fim, 1'b0);
      step(0, 1, 0, 0, 4'h0);
      step(1, 1, 0, 0, 4'h0);
      chk("zeraC_priority", db_contagem, 4'h0);

`ifdef FLUXO_TIMEOUT_EN
      // Inactivity timeout rise and clear by a press
      step(0, 0, 0, 0, 4'h0);
      step(1, 0, 0, 0, 4'h0);
      k = 0;
      while (!timeout && k < 20) begin
         step(0, 0, 0, 0, 4'h0);
         k++;
      end
      chk("timeout_rise_cycles", k, TO - 1);
      step(0, 0, 0, 0, 4'h0);
      chk("timeout_held", timeout, 1'b1);
      step(0, 0, 0, 0, 4'h1);
      chk("timeout_at_pulse", timeout, 1'b1);
      step(0, 0, 0, 0, 4'h1);
      chk("timeout_cleared", timeout, 1'b0);
`endif

      // Button held through reset release gives one pulse afterwards
      do_reset(4'h8);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 4'h8);
         pulses += int'(jogada);
      end
      chk("held_through_reset", pulses, 1);

      // Randomized traffic with occasional mid-run resets
      ch = 4'h0;
      for (int i = 0; i < 800; i++) begin
         int r;
         r = int'($urandom_range(0, 11));
         if (r < 4)       ch = 4'h1 << r;
         else if (r < 8)  ch = ch;
         else if (r < 11) ch = 4'h0;
         else             ch = 4'($urandom);
         if ($urandom_range(0, 150) == 0) do_reset(ch);
         step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0, ch);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
